zbuf_mem_scheduler: RTL
=======================

# zbuf_mem_scheduler

Schedules the single shared 16-bit SRAM port between the frame/z-buffer clear engine and the rasterizer's z-tested pixel writes. Each SRAM word is {depth[1:0], color[13:0]}. The block issues a read-compare-conditional-write sequence per pixel. It sweeps the buffer to a far-depth clear value on command. Memory is touched only while video is blanked (iVIDEO_ON low). It sits between the EdgeRasterizer pixel output and the GPU SRAM pins.

## Interface
- H_RES, 640, pixels per row
- V_RES, 400, rows
- CLEAR_VALUE, 16'hC000, clear word (depth 2'b11 = far, color 0)

Ports:
- iCLK  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- iVIDEO_ON  in  1  high = SRAM owned by scan-out; no new access may start
- iCLEAR_START  in  1  one-cycle request to clear the whole buffer
- oCLEAR_BUSY  out  1  high while a clear is pending or running
- oCLEAR_DONE  out  1  one-cycle pulse after the last clear write
- iPIX_VALID  in  1  pixel request valid
- oPIX_READY  out  1  pixel accepted on an edge where iPIX_VALID & oPIX_READY
- iPIX_X, iPIX_Y  in  10 each  pixel coordinates
- iPIX_DATA  in  16  {depth[15:14], color[13:0]}
- oPIX_WRITTEN  out  1  one-cycle pulse: pixel committed to SRAM
- oPIX_REJECTED  out  1  one-cycle pulse: pixel failed the depth test or was clipped
- iGPU_DATA  in  16  SRAM read data (asynchronous SRAM, valid in the same cycle as address/read)
- oGPU_DATA  out  16  SRAM write data
- oMEM_ADDR  out  18  SRAM word address
- oMEM_READ, oMEM_WRITE  out  1 each  SRAM strobes

## Operation
- States: IDLE, CLEAR, RD, CMP_WR, WR.
- All SRAM outputs are registered. Idle bus values: READ=0, WRITE=0, ADDR=0, GPU_DATA=CLEAR_VALUE.
- Address = y*H_RES + x, computed in 18 bits.
- oPIX_READY = (state==IDLE) & !iVIDEO_ON & !clear_pending & !iCLEAR_START. It is combinational from registers and inputs.
- iCLEAR_START in any state sets clear_pending.
  - IDLE with clear_pending and !iVIDEO_ON → CLEAR, starting at address 0.
  - iCLEAR_START while in CLEAR restarts the sweep at address 0.
  - A pixel sequence in flight completes before CLEAR begins.
- CLEAR: one write per cycle of CLEAR_VALUE, address incrementing to H_RES*V_RES-1 (255999).
  - If iVIDEO_ON is high, the write strobe is deasserted and the address is held; the sweep resumes at the same address.
  - After the last write: → IDLE, pending cleared, oCLEAR_DONE pulses, oCLEAR_BUSY falls.
- Pixel accept in IDLE:
  - Clipped pixel (x ≥ H_RES or y ≥ V_RES): no memory access, oPIX_REJECTED pulses, state stays IDLE.
  - Otherwise: → RD.
- RD: drive ADDR with READ=1 and sample iGPU_DATA.
  - Write if new depth ≤ stored depth (unsigned 2-bit): drive WRITE=1 with GPU_DATA=iPIX_DATA at the same ADDR, → WR.
  - Else: bus idle, oPIX_REJECTED, → IDLE.
- WR: bus idle, oPIX_WRITTEN, → IDLE.
- iVIDEO_ON rising during RD or WR does not abort; the sequence completes.
- Simultaneous iCLEAR_START and iPIX_VALID in IDLE: the clear wins and the pixel is not accepted.
- Reset mid-operation: immediate abort, state IDLE, pending and counters zeroed, all outputs at idle values. oPIX_READY stays low while reset is high.

## Timing
- Pixel accepted on edge N:
  - Edge N: READ=1, ADDR valid.
  - Edge N+1: WRITE=1, or oPIX_REJECTED=1.
  - Edge N+2: oPIX_WRITTEN=1.
- Throughput: 3 cycles per written pixel, 2 per rejected pixel, 1 per clipped pixel.
- Clear start sampled on edge N: the write to address 0 appears on edge N+1 (IDLE→CLEAR transition). With no video interruption, the last write appears on edge N+256000.
- oCLEAR_DONE pulses on the edge after the last write.
- Reset values: oCLEAR_BUSY=0, oCLEAR_DONE=0, oPIX_WRITTEN=0, oPIX_REJECTED=0, oMEM_READ=0, oMEM_WRITE=0, oMEM_ADDR=0, oGPU_DATA=CLEAR_VALUE.

## Configuration
- ZBUF_DEPTH_TEST_EN defined: depth test as described (RD → compare → WR).
- ZBUF_DEPTH_TEST_EN undefined:
  - Non-clipped pixels skip RD and iGPU_DATA is ignored.
  - Accept on edge N drives WRITE=1 on edge N; edge N+1 gives bus idle and oPIX_WRITTEN.
  - Throughput is 2 cycles per pixel.
  - oPIX_REJECTED fires only for clipped pixels.

## Test plan
- Reset asserted mid-RD → all outputs at reset values the same cycle; oPIX_READY=0 until reset falls.
- iCLEAR_START, iVIDEO_ON=0 → exactly 256000 writes of 16'hC000 at addresses 0..255999 in order; one oCLEAR_DONE pulse.
- Clear with iVIDEO_ON high for 10 cycles mid-sweep at address 1000 → no writes during those cycles; resumes at 1000; total write count still 256000.
- Stored 16'hC000 at addr 1290; pixel x=10, y=2, data 16'h4ABC → read at 1290, write 16'h4ABC at 1290, oPIX_WRITTEN on N+2.
- Stored 16'h4ABC at addr 1290; pixel x=10, y=2, data 16'hC123 → no write; oPIX_REJECTED on N+1.
- Pixel x=640, y=0 → no READ/WRITE strobes; oPIX_REJECTED next cycle. With ZBUF_DEPTH_TEST_EN undefined, pixel x=1, y=0 → oMEM_READ stays 0, write at addr 1 on the accept edge.

Source files
------------

// File: rtl/zbuf_mem_scheduler.sv
// Arbitrates the single SRAM port between a full-buffer clear sweep and rasterizer pixel writes.
// Macro ZBUF_DEPTH_TEST_EN enables read-compare-conditional-write; without it pixels are written blind.
module zbuf_mem_scheduler #(
  parameter int          H_RES       = 640,
  parameter int          V_RES       = 400,
  parameter logic [15:0] CLEAR_VALUE = 16'hC000
) (
  input  logic        iCLK,
  input  logic        reset,
  input  logic        iVIDEO_ON,
  input  logic        iCLEAR_START,
  output logic        oCLEAR_BUSY,
  output logic        oCLEAR_DONE,
  input  logic        iPIX_VALID,
  output logic        oPIX_READY,
  input  logic [9:0]  iPIX_X,
  input  logic [9:0]  iPIX_Y,
  input  logic [15:0] iPIX_DATA,
  output logic        oPIX_WRITTEN,
  output logic        oPIX_REJECTED,
  input  logic [15:0] iGPU_DATA,
  output logic [15:0] oGPU_DATA,
  output logic [17:0] oMEM_ADDR,
  output logic        oMEM_READ,
  output logic        oMEM_WRITE
);

  localparam logic [17:0] LAST_ADDR = 18'(H_RES * V_RES - 1);
  localparam logic [17:0] ROW_WORDS = 18'(H_RES);
  localparam logic [10:0] X_LIMIT   = 11'(H_RES);
  localparam logic [10:0] Y_LIMIT   = 11'(V_RES);

  typedef enum logic [2:0] {IDLE, CLEAR, RD, CMP_WR, WR} state_t;

  state_t      state, state_nxt;
  logic        clear_pending, pending_nxt;
  logic [17:0] addr_nxt;
  logic [15:0] dat_nxt;
  logic        rd_nxt, wr_nxt;
  logic        written_nxt, rejected_nxt, done_nxt;
  logic        pix_fire, pix_clip;
  logic [17:0] pix_addr;
  logic        unused_gpu_bits;

  assign oPIX_READY  = (state == IDLE) & ~iVIDEO_ON & ~clear_pending & ~iCLEAR_START & ~reset;
  assign oCLEAR_BUSY = clear_pending;
  assign pix_fire    = iPIX_VALID & oPIX_READY;
  assign pix_clip    = ({1'b0, iPIX_X} >= X_LIMIT) | ({1'b0, iPIX_Y} >= Y_LIMIT);
  assign pix_addr    = {8'd0, iPIX_Y} * ROW_WORDS + {8'd0, iPIX_X};

`ifdef ZBUF_DEPTH_TEST_EN
  logic [15:0] pix_dat, pix_dat_nxt;

  // Only the stored depth bits take part in the test; color is overwritten wholesale.
  assign unused_gpu_bits = ^iGPU_DATA[13:0];

  always_ff @(posedge iCLK or posedge reset) begin
    if (reset) pix_dat <= '0;
    else       pix_dat <= pix_dat_nxt;
  end
`else
  assign unused_gpu_bits = ^iGPU_DATA;
`endif

  always_comb begin
    state_nxt    = state;
    pending_nxt  = clear_pending | iCLEAR_START;
    addr_nxt     = '0;
    dat_nxt      = CLEAR_VALUE;
    rd_nxt       = 1'b0;
    wr_nxt       = 1'b0;
    written_nxt  = 1'b0;
    rejected_nxt = 1'b0;
    done_nxt     = 1'b0;
`ifdef ZBUF_DEPTH_TEST_EN
    pix_dat_nxt  = pix_dat;
`endif
    case (state)
      IDLE: begin
        if (clear_pending && !iVIDEO_ON) begin
          state_nxt = CLEAR;
          wr_nxt    = 1'b1;
        end else if (pix_fire) begin
          if (pix_clip) begin
            rejected_nxt = 1'b1;
          end else begin
`ifdef ZBUF_DEPTH_TEST_EN
            state_nxt   = RD;
            rd_nxt      = 1'b1;
            addr_nxt    = pix_addr;
            pix_dat_nxt = iPIX_DATA;
`else
            state_nxt = WR;
            wr_nxt    = 1'b1;
            addr_nxt  = pix_addr;
            dat_nxt   = iPIX_DATA;
`endif
          end
        end
      end
      CLEAR: begin
        // oMEM_ADDR is the sweep pointer; it advances only past a write that actually went out.
        if (iCLEAR_START) begin
          addr_nxt = '0;
          wr_nxt   = ~iVIDEO_ON;
        end else if (oMEM_WRITE && (oMEM_ADDR == LAST_ADDR)) begin
          state_nxt   = IDLE;
          pending_nxt = 1'b0;
          done_nxt    = 1'b1;
        end else begin
          addr_nxt = oMEM_WRITE ? oMEM_ADDR + 18'd1 : oMEM_ADDR;
          wr_nxt   = ~iVIDEO_ON;
        end
      end
`ifdef ZBUF_DEPTH_TEST_EN
      RD: begin
        if (pix_dat[15:14] <= iGPU_DATA[15:14]) begin
          state_nxt = WR;
          wr_nxt    = 1'b1;
          addr_nxt  = oMEM_ADDR;
          dat_nxt   = pix_dat;
        end else begin
          state_nxt    = IDLE;
          rejected_nxt = 1'b1;
        end
      end
`endif
      WR: begin
        state_nxt   = IDLE;
        written_nxt = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      clear_pending <= 1'b0;
      oMEM_ADDR     <= '0;
      oGPU_DATA     <= CLEAR_VALUE;
      oMEM_READ     <= 1'b0;
      oMEM_WRITE    <= 1'b0;
      oPIX_WRITTEN  <= 1'b0;
      oPIX_REJECTED <= 1'b0;
      oCLEAR_DONE   <= 1'b0;
    end else begin
      state         <= state_nxt;
      clear_pending <= pending_nxt;
      oMEM_ADDR     <= addr_nxt;
      oGPU_DATA     <= dat_nxt;
      oMEM_READ     <= rd_nxt;
      oMEM_WRITE    <= wr_nxt;
      oPIX_WRITTEN  <= written_nxt;
      oPIX_REJECTED <= rejected_nxt;
      oCLEAR_DONE   <= done_nxt;
    end
  end

endmodule
